dap_shift_sequencer: RTL and testbench
======================================

// Module: dap_shift_sequencer
// PURPOSE
//  Bit-level shift engine for the SWD/JTAG pin path. Accepts one transfer command (1..32 bits,
//  LSB first), enables the baud generator, and drives or samples one bit per generated SCLK period.
//  Drives on the generator's sclk_negedge strobe; samples on its sclk_sampling strobe.
//  Sits between the DAP command processor and the baud generator / GPIO pin mux.
//  Strobes are single-cycle pulses, synchronous to clk (the generator's sclk_in is tied to clk).
// PARAMETERS
//  DW          32     max bits per command; also data width
//  LENW        6      width of cmd_len; must satisfy 2**LENW > DW
//  TIMEOUT     65535  clk cycles without any strobe while active -> abort with error
// PORTS
//  clk            in   1     system clock
//  reset          in   1     synchronous, active-high reset
//  cmd_valid      in   1     command handshake valid
//  cmd_ready      out  1     command handshake ready
//  cmd_len        in   LENW  bit count; valid range 1..DW
//  cmd_wdata      in   DW    bits to drive, bit0 first
//  cmd_drive      in   1     1: drive io_out with io_oe=1; 0: read-only/turnaround, io_oe=0
//  rsp_valid      out  1     response handshake valid
//  rsp_ready      in   1     response handshake ready
//  rsp_rdata      out  DW    sampled bits; bit i = i-th sample; bits >= len are 0
//  rsp_err        out  1     1: bad length or strobe timeout
//  baud_cen       out  1     enable to the baud generator
//  sclk_negedge   in   1     generator drive-point strobe
//  sclk_sampling  in   1     generator sample-point strobe
//  io_in          in   1     pin input (already synchronised)
//  io_out         out  1     pin output data
//  io_oe          out  1     pin output enable
//  busy           out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, baud_cen=0, io_out=0,
//   io_oe=0, busy=0. FSM returns to IDLE. A reset mid-transfer abandons the transfer and
//   produces no response.
//  FSM states: IDLE, WAIT_FIRST, SHIFT, RESP.
//  IDLE: cmd_ready=1. The command is accepted on cmd_valid&cmd_ready.
//   - cmd_len==0 or cmd_len>DW: go directly to RESP with rsp_err=1 and rdata=0. baud_cen stays 0.
//   - Otherwise: latch wdata/len/drive, clear bit_cnt and rdata, set baud_cen=1 on the next
//     cycle, go to WAIT_FIRST.
//  WAIT_FIRST: sclk_sampling strobes are ignored. On sclk_negedge:
//   - io_out<=wdata[0] and io_oe<=cmd_drive; go to SHIFT.
//  SHIFT: on sclk_sampling, rdata[bit_cnt]<=io_in and set a per-bit 'sampled' flag.
//   On sclk_negedge with 'sampled' set:
//   - bit_cnt+1==len: go to RESP, baud_cen<=0, io_oe<=0.
//   - Otherwise: bit_cnt++, io_out<=wdata[bit_cnt+1], clear 'sampled'.
//   A negedge without a prior sample in the same bit is ignored (counter holds).
//   Both strobes in the same cycle: sample first, then evaluate negedge using the updated flag.
//  RESP: rsp_valid=1; rsp_rdata and rsp_err are stable until rsp_valid&rsp_ready; then go to IDLE.
//   cmd_ready=0 in every non-IDLE state, so there is no back-to-back accept in the RESP cycle.
//  Watchdog: 17-bit counter, cleared on any strobe and on entry to WAIT_FIRST. It counts only
//   in WAIT_FIRST/SHIFT. Reaching TIMEOUT: go to RESP with rsp_err=1, keep partial rdata,
//   baud_cen=0, io_oe=0.
//  Latency: accept->baud_cen 1 cycle; last negedge strobe->rsp_valid 1 cycle.
//  io_out holds its last value between transfers; only io_oe is forced to 0.
// STRUCTURE
//  Shared package (dap_pkg): FSM state encoding, DAP_DW, DAP_LENW, default TIMEOUT.
//  One sub-module is natural: dap_strobe_watchdog (counter, clear, enable, expired).
//  Everything else stays flat in this module.
// TESTING
//  Generator model: negedge strobe every 8 clk; sampling strobe 4 clk after each negedge.
//  1. len=8, wdata=0xA5, drive=1, io_in looped to io_out
//     -> io_out sequence 1,0,1,0,0,1,0,1; rsp_rdata=0xA5; err=0.
//  2. len=32, drive=0, io_in driven with 0xDEADBEEF LSB first
//     -> io_oe stays 0 throughout; rsp_rdata=0xDEADBEEF.
//  3. len=0, then len=33 -> each gives an immediate rsp_err=1, rdata=0; baud_cen never asserts.
//  4. Both strobes coincide every cycle for len=3 -> exactly 3 bits sampled; bit_cnt never skips.
//  5. Strobes stop after 2 bits of len=8, TIMEOUT=100 -> rsp_err=1 at ~100 clk; rdata[1:0] kept.
//  6. Reset asserted mid-SHIFT; rsp_ready held 0 in RESP for 20 cycles
//     -> all outputs return to reset values, no response; the response is held stable.

Source files
------------

// File: rtl/dap_pkg.sv
// Shared definitions for the DAP shift sequencer slice.
// Contents:
//   DAP_DW      - default data width and maximum bits per command
//   DAP_LENW    - default width of the command length field
//   DAP_TIMEOUT - default strobe watchdog limit in clk cycles
//   DAP_WDW     - width of the strobe watchdog counter
//   dap_state_t - sequencer FSM state encoding
package dap_pkg;

  localparam int DAP_DW      = 32;
  localparam int DAP_LENW    = 6;
  localparam int DAP_TIMEOUT = 65535;
  localparam int DAP_WDW     = 17;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_SHIFT      = 2'd2,
    ST_RESP       = 2'd3
  } dap_state_t;

endpackage

// File: rtl/dap_strobe_watchdog.sv
// Strobe watchdog for the DAP shift sequencer.
// Counts clk cycles while enabled and flags expiry once the count reaches
// TIMEOUT. Any clear (strobe seen, or sequencer not shifting) restarts it.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   clear   in  restart the count from zero (wins over enable)
//   enable  in  count this cycle
//   expired out count has reached TIMEOUT
module dap_strobe_watchdog
  import dap_pkg::*;
#(
  parameter int TIMEOUT = DAP_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [DAP_WDW-1:0] count;

  assign expired = (count >= DAP_WDW'(TIMEOUT));

  // The count freezes once expired so it can never wrap back below the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + DAP_WDW'(1);
    end
  end

endmodule

// File: rtl/dap_shift_sequencer.sv
// Bit-level shift engine for the SWD/JTAG pin path.
// Accepts one command of 1..DW bits (LSB first), enables the baud generator,
// drives one bit on each sclk_negedge strobe and samples one bit on each
// sclk_sampling strobe, then returns the sampled word as a response.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_len/cmd_wdata/cmd_drive bit count, bits to drive, drive enable
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/rsp_err           sampled bits, bad length or timeout flag
//   baud_cen                    enable to the baud generator
//   sclk_negedge/sclk_sampling  generator drive / sample strobes
//   io_in/io_out/io_oe          pin input, output data, output enable
//   busy                        high whenever not idle
module dap_shift_sequencer
  import dap_pkg::*;
#(
  parameter int DW      = DAP_DW,
  parameter int LENW    = DAP_LENW,
  parameter int TIMEOUT = DAP_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [LENW-1:0] cmd_len,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic            cmd_drive,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            baud_cen,
  input  logic            sclk_negedge,
  input  logic            sclk_sampling,
  input  logic            io_in,
  output logic            io_out,
  output logic            io_oe,
  output logic            busy
);

  dap_state_t      state, state_n;
  logic [LENW-1:0] len_q, len_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic            drive_q, drive_n;
  logic [LENW-1:0] bit_cnt, cnt_n;
  logic [DW-1:0]   rdata_q, rdata_n;
  logic            err_q, err_n;
  logic            sampled, sampled_n, sampled_v;
  logic            baud_q, baud_n;
  logic            io_out_q, io_out_n;
  logic            io_oe_q, io_oe_n;

  logic [LENW-1:0] cnt_inc;
  logic [DW-1:0]   bit_mask;
  logic            len_bad;
  logic            wd_active;
  logic            wd_clear;
  logic            wd_expired;

  assign cnt_inc  = bit_cnt + LENW'(1);
  assign bit_mask = {{(DW-1){1'b0}}, 1'b1} << bit_cnt;
  assign len_bad  = (cmd_len == '0) || (cmd_len > LENW'(DW));

  // The watchdog only runs while waiting on strobes; holding it in clear
  // outside those states also gives a fresh count on entry to WAIT_FIRST.
  assign wd_active = (state == ST_WAIT_FIRST) || (state == ST_SHIFT);
  assign wd_clear  = sclk_negedge || sclk_sampling || !wd_active;

  dap_strobe_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_active),
    .expired(wd_expired)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign baud_cen  = baud_q;
  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      wdata_q  <= '0;
      drive_q  <= 1'b0;
      bit_cnt  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sampled  <= 1'b0;
      baud_q   <= 1'b0;
      io_out_q <= 1'b0;
      io_oe_q  <= 1'b0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      wdata_q  <= wdata_n;
      drive_q  <= drive_n;
      bit_cnt  <= cnt_n;
      rdata_q  <= rdata_n;
      err_q    <= err_n;
      sampled  <= sampled_n;
      baud_q   <= baud_n;
      io_out_q <= io_out_n;
      io_oe_q  <= io_oe_n;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_n   = state;
    len_n     = len_q;
    wdata_n   = wdata_q;
    drive_n   = drive_q;
    cnt_n     = bit_cnt;
    rdata_n   = rdata_q;
    err_n     = err_q;
    sampled_n = sampled;
    sampled_v = sampled;
    baud_n    = baud_q;
    io_out_n  = io_out_q;
    io_oe_n   = io_oe_q;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          rdata_n = '0;
          if (len_bad) begin
            err_n   = 1'b1;
            state_n = ST_RESP;
          end else begin
            err_n     = 1'b0;
            len_n     = cmd_len;
            wdata_n   = cmd_wdata;
            drive_n   = cmd_drive;
            cnt_n     = '0;
            sampled_n = 1'b0;
            baud_n    = 1'b1;
            state_n   = ST_WAIT_FIRST;
          end
        end
      end

      ST_WAIT_FIRST: begin
        if (wd_expired) begin
          err_n   = 1'b1;
          baud_n  = 1'b0;
          io_oe_n = 1'b0;
          state_n = ST_RESP;
        end else if (sclk_negedge) begin
          io_out_n = wdata_q[0];
          io_oe_n  = drive_q;
          state_n  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (wd_expired) begin
          err_n   = 1'b1;
          baud_n  = 1'b0;
          io_oe_n = 1'b0;
          state_n = ST_RESP;
        end else begin
          // Sample first so a coincident negedge sees this bit as sampled.
          if (sclk_sampling) begin
            rdata_n   = io_in ? (rdata_q | bit_mask) : (rdata_q & ~bit_mask);
            sampled_v = 1'b1;
          end
          // A negedge before this bit was sampled is ignored.
          if (sclk_negedge && sampled_v) begin
            if (cnt_inc == len_q) begin
              baud_n  = 1'b0;
              io_oe_n = 1'b0;
              state_n = ST_RESP;
            end else begin
              cnt_n     = cnt_inc;
              io_out_n  = |(wdata_q & (bit_mask << 1));
              sampled_v = 1'b0;
            end
          end
          sampled_n = sampled_v;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dap_shift_sequencer.sv
// Self-checking bench for dap_shift_sequencer.
// A behavioural baud generator produces the strobes; expected results come
// from the command fields and the pattern put on io_in.
module tb_dap_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_drive = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        sclk_negedge = 1'b0;
  logic        sclk_sampling = 1'b0;
  logic        io_in = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, baud_cen, io_out, io_oe, busy;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad = 0;

  dap_shift_sequencer #(
    .DW(32), .LENW(6), .TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_wdata(cmd_wdata), .cmd_drive(cmd_drive),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .baud_cen(baud_cen),
    .sclk_negedge(sclk_negedge), .sclk_sampling(sclk_sampling),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Activity monitors used to prove something never happened in a window.
  int baud_cnt = 0;
  int oe_cnt = 0;
  int rv_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (baud_cen) baud_cnt++;
    if (io_oe) oe_cnt++;
    if (rsp_valid) rv_cnt++;
  end

  // Generator model: mode 1 = negedge every 8 clk with a sample 4 clk later,
  // mode 2 = both strobes every cycle. Stops after gen_max_neg negedges.
  int          gen_mode = 1;
  int          gen_max_neg = 1000;
  logic [31:0] pat = '0;
  bit          loop_mode = 1'b0;
  logic [31:0] obs_out = '0;
  logic [31:0] obs_oe = '0;
  int          last_neg_cyc = 0;
  int          last_strobe_cyc = 0;
  int          phase = 0;
  int          neg_cnt = 0;
  int          samp_idx = 0;
  bit          neg_seen = 1'b0;
  bit          emit_neg, emit_samp;

  always @(posedge clk) begin
    #1;
    sclk_negedge  = 1'b0;
    sclk_sampling = 1'b0;
    if (reset || !baud_cen || gen_mode == 0) begin
      phase = 0; neg_cnt = 0; samp_idx = 0; neg_seen = 1'b0;
    end else begin
      phase++;
      if (phase == 1) begin
        obs_out = '0;
        obs_oe  = '0;
      end
      emit_neg  = (gen_mode == 2) || (phase % 8 == 0);
      emit_samp = (gen_mode == 2) || (phase % 8 == 4);
      if (neg_cnt >= gen_max_neg) begin
        emit_neg  = 1'b0;
        emit_samp = 1'b0;
      end
      if (emit_samp) begin
        if (neg_seen && samp_idx < 32) begin
          io_in = loop_mode ? io_out : pat[samp_idx[4:0]];
          obs_out[samp_idx[4:0]] = io_out;
          obs_oe[samp_idx[4:0]]  = io_oe;
          samp_idx++;
        end else begin
          io_in = 1'($urandom_range(0, 1));
        end
      end
      if (emit_neg) begin
        neg_cnt++;
        neg_seen = 1'b1;
        last_neg_cyc = cyc;
      end
      if (emit_neg || emit_samp) last_strobe_cyc = cyc;
      sclk_negedge  = emit_neg;
      sclk_sampling = emit_samp;
    end
  end

  function automatic logic [31:0] len_mask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  task automatic start_cmd(input logic [5:0] len, input logic [31:0] wd, input logic drv);
    cmd_len = len; cmd_wdata = wd; cmd_drive = drv; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic recover();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_xfer(input logic [5:0] len, input logic [31:0] wd, input logic drv,
                          input logic [31:0] p, input bit lp, input int mode,
                          output bit found, output logic [31:0] rd, output logic er,
                          output int acc_cyc, output int rcyc, output logic acc_baud);
    pat = p; loop_mode = lp; gen_mode = mode;
    start_cmd(len, wd, drv);
    acc_cyc  = cyc;
    acc_baud = baud_cen;
    wait_rsp(2000, found);
    rcyc = cyc; rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, baud_cen, io_out, io_oe, busy} !== 7'b1000000) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want 1000000",
               {cmd_ready, rsp_valid, rsp_err, baud_cen, io_out, io_oe, busy});
    end
    total++;
    if (rsp_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_rdata: got %h want 0", rsp_rdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, busy} !== 2'b10) begin
      bad++; $display("[TB] FAIL idle_after_reset: got %b want 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_loopback_a5();
    bit found; logic [31:0] rd; logic er, ab; int ac, rc;
    run_xfer(6'd8, 32'h0000_00A5, 1'b1, 32'h0, 1'b1, 1, found, rd, er, ac, rc, ab);
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL a5_rsp_timeout: got none want rsp_valid"); recover(); return;
    end
    total++;
    if (ab !== 1'b1) begin bad++; $display("[TB] FAIL a5_baud_latency: got %b want 1", ab); end
    total++;
    if (rd !== 32'hA5) begin bad++; $display("[TB] FAIL a5_rdata: got %h want a5", rd); end
    total++;
    if (er !== 1'b0) begin bad++; $display("[TB] FAIL a5_err: got %b want 0", er); end
    total++;
    if (obs_out[7:0] !== 8'hA5) begin
      bad++; $display("[TB] FAIL a5_io_out_seq: got %h want a5", obs_out[7:0]);
    end
    total++;
    if (obs_oe[7:0] !== 8'hFF) begin
      bad++; $display("[TB] FAIL a5_io_oe: got %h want ff", obs_oe[7:0]);
    end
    total++;
    if (rc !== last_neg_cyc + 1) begin
      bad++; $display("[TB] FAIL a5_rsp_latency: got %0d want %0d", rc, last_neg_cyc + 1);
    end
    ack_rsp();
    total++;
    if ({cmd_ready, rsp_valid, io_oe, baud_cen, io_out} !== 5'b10001) begin
      bad++; $display("[TB] FAIL a5_after_ack: got %b want 10001",
                      {cmd_ready, rsp_valid, io_oe, baud_cen, io_out});
    end
  endtask

  task automatic test_read_deadbeef();
    bit found; logic [31:0] rd; logic er, ab; int ac, rc, oe0;
    oe0 = oe_cnt;
    run_xfer(6'd32, $urandom, 1'b0, 32'hDEADBEEF, 1'b0, 1, found, rd, er, ac, rc, ab);
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL rd32_rsp_timeout: got none want rsp_valid"); recover(); return;
    end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd32_rdata: got %h want deadbeef", rd); end
    total++;
    if (er !== 1'b0) begin bad++; $display("[TB] FAIL rd32_err: got %b want 0", er); end
    ack_rsp();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (oe_cnt - oe0 !== 0) begin
      bad++; $display("[TB] FAIL rd32_io_oe_cycles: got %0d want 0", oe_cnt - oe0);
    end
  endtask

  task automatic test_bad_length();
    logic [5:0] lens [3];
    int b0;
    lens[0] = 6'd0; lens[1] = 6'd33; lens[2] = 6'($urandom_range(34, 63));
    for (int k = 0; k < 3; k++) begin
      b0 = baud_cnt;
      start_cmd(lens[k], $urandom, 1'b1);
      total++;
      if ({rsp_valid, rsp_err, baud_cen} !== 3'b110) begin
        bad++; $display("[TB] FAIL badlen_%0d_resp: got %b want 110", lens[k],
                        {rsp_valid, rsp_err, baud_cen});
      end
      total++;
      if (rsp_rdata !== 32'h0) begin
        bad++; $display("[TB] FAIL badlen_%0d_rdata: got %h want 0", lens[k], rsp_rdata);
      end
      ack_rsp();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (baud_cnt - b0 !== 0) begin
        bad++; $display("[TB] FAIL badlen_%0d_baud: got %0d want 0", lens[k], baud_cnt - b0);
      end
    end
  endtask

  task automatic test_coincident();
    bit found; logic [31:0] rd, p; logic er, ab; int ac, rc;
    p = $urandom;
    run_xfer(6'd3, 32'hFFFF_FFF5, 1'b1, p, 1'b0, 2, found, rd, er, ac, rc, ab);
    gen_mode = 1;
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL coin_rsp_timeout: got none want rsp_valid"); recover(); return;
    end
    total++;
    if (rd !== (p & 32'h7)) begin bad++; $display("[TB] FAIL coin_rdata: got %h want %h", rd, p & 32'h7); end
    total++;
    if (obs_out[2:0] !== 3'b101) begin
      bad++; $display("[TB] FAIL coin_io_out_seq: got %b want 101", obs_out[2:0]);
    end
    total++;
    if (rc - ac !== 4) begin bad++; $display("[TB] FAIL coin_cycles: got %0d want 4", rc - ac); end
    ack_rsp();
  endtask

  task automatic test_timeout();
    bit found; logic [31:0] rd, p; logic er, ab; int ac, rc, d;
    p = $urandom;
    gen_max_neg = 3;
    run_xfer(6'd8, $urandom, 1'b1, p, 1'b0, 1, found, rd, er, ac, rc, ab);
    gen_max_neg = 1000;
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL to_rsp_timeout: got none want rsp_valid"); recover(); return;
    end
    total++;
    if (er !== 1'b1) begin bad++; $display("[TB] FAIL to_err: got %b want 1", er); end
    total++;
    if (rd !== (p & 32'h3)) begin bad++; $display("[TB] FAIL to_partial_rdata: got %h want %h", rd, p & 32'h3); end
    d = rc - last_strobe_cyc;
    total++;
    if (!(d >= 95 && d <= 110)) begin bad++; $display("[TB] FAIL to_delay: got %0d want 95..110", d); end
    total++;
    if ({baud_cen, io_oe} !== 2'b00) begin
      bad++; $display("[TB] FAIL to_pins: got %b want 00", {baud_cen, io_oe});
    end
    ack_rsp();
  endtask

  task automatic test_reset_midshift();
    int r0;
    pat = $urandom; loop_mode = 1'b0; gen_mode = 1;
    start_cmd(6'd16, $urandom, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    total++;
    if ({busy, io_oe, baud_cen} !== 3'b111) begin
      bad++; $display("[TB] FAIL mid_active: got %b want 111", {busy, io_oe, baud_cen});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, baud_cen, io_out, io_oe, busy} !== 7'b1000000
        || rsp_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL mid_reset_values: got %b/%h want 1000000/0",
                      {cmd_ready, rsp_valid, rsp_err, baud_cen, io_out, io_oe, busy}, rsp_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = rv_cnt;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (rv_cnt - r0 !== 0 || cmd_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_no_response: got %0d/%b want 0/1", rv_cnt - r0, cmd_ready);
    end
  endtask

  task automatic test_hold_response();
    bit found; logic [31:0] rd, p, exp; logic er, ab; int ac, rc;
    p = $urandom;
    exp = p & len_mask(12);
    run_xfer(6'd12, $urandom, 1'b0, p, 1'b0, 1, found, rd, er, ac, rc, ab);
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL hold_rsp_timeout: got none want rsp_valid"); recover(); return;
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp}) begin
        bad++; $display("[TB] FAIL hold_cycle_%0d: got %b/%b/%h want 1/0/%h",
                        i, rsp_valid, rsp_err, rsp_rdata, exp);
      end
      @(posedge clk); #1;
    end
    ack_rsp();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_release: got %b want 0", rsp_valid); end
  endtask

  task automatic test_random();
    bit found; logic [31:0] rd, p, wd, m; logic er, ab, drv; int ac, rc, n;
    for (int k = 0; k < 6; k++) begin
      n   = $urandom_range(1, 32);
      p   = $urandom;
      wd  = $urandom;
      drv = 1'($urandom_range(0, 1));
      m   = len_mask(n);
      run_xfer(6'(n), wd, drv, p, 1'b0, 1, found, rd, er, ac, rc, ab);
      total++;
      if (!found) begin
        bad++; $display("[TB] FAIL rnd%0d_rsp_timeout: got none want rsp_valid", k); recover(); continue;
      end
      total++;
      if (rd !== (p & m) || er !== 1'b0) begin
        bad++; $display("[TB] FAIL rnd%0d_rsp: got %h/%b want %h/0 len=%0d", k, rd, er, p & m, n);
      end
      total++;
      if ((obs_out & m) !== (wd & m)) begin
        bad++; $display("[TB] FAIL rnd%0d_io_out: got %h want %h", k, obs_out & m, wd & m);
      end
      total++;
      if ((obs_oe & m) !== (drv ? m : 32'h0)) begin
        bad++; $display("[TB] FAIL rnd%0d_io_oe: got %h want %h", k, obs_oe & m, drv ? m : 32'h0);
      end
      total++;
      if (rc !== last_neg_cyc + 1) begin
        bad++; $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", k, rc, last_neg_cyc + 1);
      end
      ack_rsp();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_time_limit: got expired want finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    $display("[TB] start");
    test_reset();
    test_loopback_a5();
    test_read_deadbeef();
    test_bad_length();
    test_coincident();
    test_timeout();
    test_reset_midshift();
    test_hold_response();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
